// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Holds the loader FSM state enum, frame constants and an address helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Byte address of word idx; upper bits are always zero.
    function automatic logic [63:0] word_addr(input logic [15:0] idx);
        return {46'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
// master = host/memory side, slave = loader side.
interface imem_loader_if;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: gathers bytes LSB-first into a 32-bit little-endian word.
// Ports: clk, reset, clear, shift_en, byte_in -> word_full (pulse), word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [31:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= 2'd0;
            sr_q  <= 32'd0;
        end else if (shift_en) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {byte_in, sr_q[31:8]};
        end
    end

    // The word is presented together with its last byte, so the
    // write can be registered on the very edge that accepts it.
    assign word_full = shift_en && (cnt_q == 2'(WORD_BYTES - 1));
    assign word      = {byte_in, sr_q[31:8]};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> instruction memory writer, holds CPU in
// reset until a checksummed load succeeds. Ports: clk, reset, start, bus
// (stream + imem write), cpu_reset, busy, done, error.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    loader_state_t state_q;
    loader_state_t state_d;

    logic [7:0]  cnt_lo_q;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [7:0]  chk_q;
    logic        we_q;
    logic [63:0] addr_q;
    logic [31:0] wdata_q;
    logic        cpu_reset_q;

    logic        xfer;
    logic [15:0] hdr_cnt;
    logic        last_word;
    logic        word_full;
    logic [31:0] word;

    logic clear;
    logic lo_en;
    logic cnt_en;
    logic shift;
    logic wr;
    logic chk_ok;

    assign busy      = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                       (state_q == ST_DATA) || (state_q == ST_CHK);
    assign xfer      = bus.in_valid && busy;
    assign hdr_cnt   = {bus.in_data, cnt_lo_q};
    assign last_word = (word_idx_q == count_q - 16'd1);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .shift_en  (shift),
        .byte_in   (bus.in_data),
        .word_full (word_full),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        lo_en   = 1'b0;
        cnt_en  = 1'b0;
        shift   = 1'b0;
        wr      = 1'b0;
        chk_ok  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR0;
                    clear   = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_HDR0;
                    clear   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR0: begin
                if (xfer) begin
                    lo_en   = 1'b1;
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (xfer) begin
                    cnt_en = 1'b1;
                    if (hdr_cnt == 16'd0 || {1'b0, hdr_cnt} > MAX_W)
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    shift = 1'b1;
                    if (word_full) begin
                        wr = 1'b1;
                        if (last_word) state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (bus.in_data == chk_q) begin
                        chk_ok  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lo_q    <= 8'd0;
            count_q     <= 16'd0;
            word_idx_q  <= 16'd0;
            chk_q       <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= 64'd0;
            wdata_q     <= 32'd0;
            cpu_reset_q <= 1'b1;
        end else begin
            we_q <= wr;
            if (clear) begin
                word_idx_q  <= 16'd0;
                chk_q       <= 8'd0;
                cpu_reset_q <= 1'b1;
            end
            if (lo_en)  cnt_lo_q <= bus.in_data;
            if (cnt_en) count_q  <= hdr_cnt;
            if (shift)  chk_q    <= chk_q ^ bus.in_data;
            if (wr) begin
                addr_q     <= word_addr(word_idx_q);
                wdata_q    <= word;
                word_idx_q <= word_idx_q + 16'd1;
            end
            if (chk_ok) cpu_reset_q <= 1'b0;
        end
    end

    assign bus.in_ready   = busy;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign done           = (state_q == ST_DONE);
    assign error          = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames checked against a frame/word model.
// Logs every memory write and done pulse, compares with expected words.
module tb_imem_loader;

    localparam int MAXW = 16;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset;
    logic busy;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;

    logic [63:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    logic [31:0] words[$];
    logic [7:0]  frame[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap_max,
                        input bit with_start);
        int g;
        bit ok;
        g = $urandom_range(gap_max, 0);
        repeat (g) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (with_start) start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        start        = 1'b0;
        if (!ok) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // Model: header count LE, data bytes LE per word, XOR checksum.
    task automatic build_frame(input bit corrupt);
        int n;
        logic [7:0] x;
        logic [7:0] b;
        n = words.size();
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(words[k] >> (8 * j));
                x ^= b;
                frame.push_back(b);
            end
        end
        frame.push_back(corrupt ? (x ^ 8'h01) : x);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back($urandom);
    endtask

    task automatic run_load(input int gap_max, input bit corrupt,
                            input int start_at);
        int n;
        int base;
        int dbase;
        n = words.size();
        build_frame(corrupt);
        base  = wr_addr_q.size();
        dbase = done_cnt;
        do_start();
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("cpurst_after_start", 64'(cpu_reset), 64'd1);
        check("err_after_start", 64'(error), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < frame.size(); i++)
            send(frame[i], gap_max, i == start_at);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(!corrupt));
        check("error_flag", 64'(error), 64'(corrupt));
        check("cpurst_end", 64'(cpu_reset), 64'(corrupt));
        check("wr_count", 64'(wr_addr_q.size() - base), 64'(n));
        for (int k = 0; k < n && base + k < wr_addr_q.size(); k++) begin
            check("wr_addr", wr_addr_q[base + k], 64'(4 * k));
            check("wr_data", 64'(wr_data_q[base + k]), 64'(words[k]));
            if (gap_max == 0 && k > 0)
                check("wr_spacing",
                      64'(wr_cyc_q[base + k] - wr_cyc_q[base + k - 1]),
                      64'd4);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("done_low", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt - dbase), 64'(!corrupt));
        check("cpurst_hold", 64'(cpu_reset), 64'(corrupt));
        check("we_idle", 64'(bus.imem_we), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_we"}, 64'(bus.imem_we), 64'd0);
        check({tag, "_addr"}, bus.imem_addr, 64'd0);
        check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, "_cpurst"}, 64'(cpu_reset), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic hdr_err(input int cnt);
        int base;
        base = wr_addr_q.size();
        do_start();
        @(negedge clk);
        check("hdr_err_cleared", 64'(error), 64'd0);
        @(posedge clk); #1;
        send(8'(cnt), 1, 1'b0);
        send(8'(cnt >> 8), 1, 1'b0);
        @(negedge clk);
        check("hdr_error", 64'(error), 64'd1);
        check("hdr_ready", 64'(bus.in_ready), 64'd0);
        check("hdr_busy", 64'(busy), 64'd0);
        check("hdr_cpurst", 64'(cpu_reset), 64'd1);
        check("hdr_nowr", 64'(wr_addr_q.size() - base), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;

        // Single word from the bring-up example, with gaps.
        words.delete();
        words.push_back(32'h9101F96F);
        run_load(3, 1'b0, -1);
        check("ex_word", 64'(wr_data_q[wr_data_q.size() - 1]),
              64'h9101F96F);

        // Three words, continuous stream.
        rand_words(3);
        run_load(0, 1'b0, -1);

        // Same frame, bad checksum.
        run_load(0, 1'b1, -1);

        // Header count 0 and MAX+1.
        hdr_err(0);
        hdr_err(MAXW + 1);

        // Largest legal count.
        rand_words(MAXW);
        run_load(0, 1'b0, -1);

        // Reset after 6 data bytes.
        rand_words(3);
        build_frame(1'b0);
        do_start();
        for (int i = 0; i < 8; i++) send(frame[i], 0, 1'b0);
        do_reset();
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rand_words(3);
        run_load(2, 1'b0, -1);

        // start pulsed during DATA is ignored.
        rand_words(2);
        run_load(1, 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
